// File: rtl/pc_fetch_ctrl.sv
// PC holder and fetch controller: sequential / redirect next-PC, valid-ready fetch to
// instruction memory, one-entry instruction buffer to decode. Option: PC_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module pc_fetch_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000,
    parameter int              INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_offset,
    input  logic            halt,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    input  logic [ILEN-1:0] ifu_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            halted,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            drop_q, drop_d;
    logic            halt_seen_q, halt_seen_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] target_raw_s;
    logic [XLEN-1:0] target_s;
    logic            redir_s;
    logic            hlt_s;
    logic            req_hs_s;

    assign target_raw_s = redirect_base + redirect_offset;
    assign hlt_s        = halt | halt_seen_q;
    assign req_hs_s     = (state_q == ST_REQ) && ifu_req_ready;

`ifdef PC_MISALIGN_CHECK_EN
    // A misaligned target cancels the redirect outright and is only reported.
    assign target_s   = target_raw_s;
    assign redir_s    = redirect_valid && ((target_raw_s & ALIGN_MASK) == {XLEN{1'b0}});
    assign misalign_d = redirect_valid && ((target_raw_s & ALIGN_MASK) != {XLEN{1'b0}})
                        && (state_q != ST_HALTED);
`else
    assign target_s   = target_raw_s & ~ALIGN_MASK;
    assign redir_s    = redirect_valid;
    assign misalign_d = 1'b0;
`endif

    // Next-state, next-PC and instruction buffer update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        drop_d       = drop_q;
        halt_seen_d  = halt_seen_q | halt;
        case (state_q)
            ST_REQ: begin
                if (hlt_s && !req_hs_s) begin
                    state_d = ST_HALTED;
                end else if (req_hs_s) begin
                    state_d = ST_WAIT;
                    if (redir_s && !hlt_s) begin
                        pc_d   = target_s;
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end else if (redir_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (ifu_rsp_valid) begin
                    drop_d = 1'b0;
                    if (hlt_s) begin
                        state_d = ST_HALTED;
                    end else if (redir_s) begin
                        pc_d    = target_s;
                        state_d = ST_REQ;
                    end else if (drop_q) begin
                        state_d = ST_REQ;
                    end else begin
                        inst_d       = ifu_rsp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = ST_DELIVER;
                    end
                end else if (redir_s && !hlt_s) begin
                    // Response for the old PC is still in flight; mark it stale.
                    pc_d   = target_s;
                    drop_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DELIVER: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    if (hlt_s) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_HALTED;
                    end else if (redir_s) begin
                        pc_d    = target_s;
                        state_d = ST_REQ;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_REQ;
                    end
                end else if (redir_s && !hlt_s) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target_s;
                    state_d      = ST_REQ;
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            ST_HALTED: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d      = ST_REQ;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_VEC;
            inst_q       <= {ILEN{1'b0}};
            inst_pc_q    <= {XLEN{1'b0}};
            inst_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            halt_seen_q  <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            drop_q       <= drop_d;
            halt_seen_q  <= halt_seen_d;
            misalign_q   <= misalign_d;
        end
    end

    // In REQ the architectural PC is always the address being requested.
    assign ifu_req_valid = (state_q == ST_REQ);
    assign ifu_req_addr  = pc_q;
    assign inst_valid    = inst_valid_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign halted        = (state_q == ST_HALTED);
    assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized phase checked against a
// PC / delivery scoreboard and an in-bench instruction memory.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RVEC = 32'h8000_0000;
`ifdef PC_MISALIGN_CHECK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_offset;
    logic        halt;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
    logic        misalign_err;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_base(redirect_base),
        .redirect_offset(redirect_offset), .halt(halt),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;
    logic [31:0] model_pc;
    logic        model_on = 1'b0;
    logic        mis_exp  = 1'b0;
    logic [31:0] req_log[$];
    logic        pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_delay;
    int          mem_max_delay = 0;
    logic        mem_hold = 1'b0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory responder, scoreboard on the events of this cycle, then advance.
    task automatic cycle();
        logic        hs;
        logic        dv;
        logic [31:0] tgt;
        if (pend && !mem_hold) begin
            if (pend_delay == 0) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_data  = imem_word(pend_addr);
                pend          = 1'b0;
            end else begin
                ifu_rsp_valid = 1'b0;
                pend_delay--;
            end
        end else begin
            ifu_rsp_valid = 1'b0;
        end
        hs = ifu_req_valid && ifu_req_ready;
        dv = inst_valid && inst_ready;
        if (hs) begin
            req_log.push_back(ifu_req_addr);
            pend       = 1'b1;
            pend_addr  = ifu_req_addr;
            pend_delay = $urandom_range(0, mem_max_delay);
        end
        if (model_on) begin
            if (hs) check("req_addr", {32'd0, ifu_req_addr}, {32'd0, model_pc});
            if (dv) begin
                check("inst_pc", {32'd0, inst_pc}, {32'd0, model_pc});
                check("inst", {32'd0, inst}, {32'd0, imem_word(model_pc)});
                model_pc = model_pc + 32'd4;
                n_deliv++;
            end
            mis_exp = 1'b0;
            if (redirect_valid) begin
                tgt = redirect_base + redirect_offset;
                if (MIS_EN && (tgt[1:0] != 2'b00)) mis_exp = 1'b1;
                else model_pc = {tgt[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        if (model_on) check("misalign_err", {63'd0, misalign_err}, {63'd0, mis_exp});
    endtask

    initial begin
        int          sz;
        int          n0;
        logic [31:0] cap_inst;
        logic [31:0] cap_pc;
        rst = 1'b0; redirect_valid = 1'b0; redirect_base = 32'd0; redirect_offset = 32'd0;
        halt = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'd0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", {63'd0, ifu_req_valid}, 64'd1);
        check("rst_req_addr", {32'd0, ifu_req_addr}, {32'd0, RVEC});
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_misalign", {63'd0, misalign_err}, 64'd0);
        rst = 1'b1; model_pc = RVEC; model_on = 1'b1;

        // Straight-line fetch with single-cycle memory.
        ifu_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (8) cycle();
        check("t1_nreq", 64'(req_log.size()), 64'd3);
        if (req_log.size() >= 3) begin
            check("t1_addr0", {32'd0, req_log[0]}, 64'h8000_0000);
            check("t1_addr1", {32'd0, req_log[1]}, 64'h8000_0004);
            check("t1_addr2", {32'd0, req_log[2]}, 64'h8000_0008);
        end

        // Decode stall: buffered instruction held, no new request until accepted.
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) cycle();
        check("t2_valid", {63'd0, inst_valid}, 64'd1);
        cap_inst = inst; cap_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_inst_hold", {32'd0, inst}, {32'd0, cap_inst});
            check("t2_pc_hold", {32'd0, inst_pc}, {32'd0, cap_pc});
            check("t2_no_req", {63'd0, ifu_req_valid}, 64'd0);
        end
        inst_ready = 1'b1;
        cycle();
        check("t2_req_after_accept", {63'd0, ifu_req_valid}, 64'd1);

        // Redirect while waiting on memory: stale response must vanish.
        mem_hold = 1'b1;
        cycle();
        redirect_valid = 1'b1; redirect_base = 32'h8000_0100; redirect_offset = 32'hFFFF_FFF0;
        ifu_req_ready = 1'b0;
        cycle();
        redirect_valid = 1'b0; mem_hold = 1'b0; ifu_req_ready = 1'b1;
        n0 = n_deliv; sz = req_log.size();
        for (int i = 0; i < 20 && req_log.size() <= sz; i++) cycle();
        check("t3_new_req", 64'(req_log.size()), 64'(sz + 1));
        check("t3_addr", {32'd0, req_log[$]}, 64'h8000_00F0);
        check("t3_no_stale", 64'(n_deliv), 64'(n0));

        // Redirect to the top of the address space, then sequential wrap.
        ifu_req_ready = 1'b0;
        for (int i = 0; i < 20 && ifu_req_valid !== 1'b1; i++) cycle();
        redirect_valid = 1'b1; redirect_base = 32'hFFFF_FFFC; redirect_offset = 32'd0;
        cycle();
        redirect_valid = 1'b0; ifu_req_ready = 1'b1; sz = req_log.size();
        for (int i = 0; i < 30 && req_log.size() < sz + 2; i++) cycle();
        check("t4_nreq", 64'(req_log.size()), 64'(sz + 2));
        if (req_log.size() >= sz + 2) begin
            check("t4_top", {32'd0, req_log[sz]}, 64'hFFFF_FFFC);
            check("t4_wrap", {32'd0, req_log[sz + 1]}, 64'h0000_0000);
        end

        // Randomized traffic against the scoreboard.
        mem_max_delay = 3; n0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            ifu_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_base   = $urandom & 32'hFFFF_FFFC;
            redirect_offset = $urandom;
            if ($urandom_range(0, 3) != 0) redirect_offset = redirect_offset & 32'hFFFF_FFFC;
            cycle();
        end
        redirect_valid = 1'b0;
        check("rand_progress", 64'(n_deliv - n0 > 50), 64'd1);

        // Asynchronous reset while waiting on memory.
        mem_max_delay = 0; inst_ready = 1'b1; ifu_req_ready = 1'b0;
        for (int i = 0; i < 40 && ifu_req_valid !== 1'b1; i++) cycle();
        ifu_req_ready = 1'b1; mem_hold = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("t6_req_valid", {63'd0, ifu_req_valid}, 64'd1);
        check("t6_req_addr", {32'd0, ifu_req_addr}, {32'd0, RVEC});
        check("t6_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("t6_inst", {32'd0, inst}, 64'd0);
        check("t6_inst_pc", {32'd0, inst_pc}, 64'd0);
        pend = 1'b0; mem_hold = 1'b0; ifu_rsp_valid = 1'b0; req_log.delete();
        mis_exp = 1'b0; model_pc = RVEC;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n0 = n_deliv;
        for (int i = 0; i < 20 && n_deliv == n0; i++) cycle();
        check("t6_first_addr", {32'd0, req_log[0]}, {32'd0, RVEC});
        ifu_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_base = 32'h8000_0000; redirect_offset = 32'h0000_0002;
        cycle();
        redirect_valid = 1'b0;
        check("t6_mis_pulse", {63'd0, misalign_err}, {63'd0, MIS_EN});
        cycle();
        check("t6_mis_clear", {63'd0, misalign_err}, 64'd0);
        ifu_req_ready = 1'b1; sz = req_log.size();
        for (int i = 0; i < 20 && req_log.size() <= sz; i++) cycle();
        check("t6_mis_addr", {32'd0, req_log[$]}, MIS_EN ? 64'h8000_0004 : 64'h8000_0000);

        // Halt during delivery: instruction handed over, then no more fetching.
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) cycle();
        check("t5_valid", {63'd0, inst_valid}, 64'd1);
        n0 = n_deliv; halt = 1'b1;
        cycle();
        halt = 1'b0;
        check("t5_delivered", 64'(n_deliv), 64'(n0 + 1));
        check("t5_halted", {63'd0, halted}, 64'd1);
        check("t5_inst_valid", {63'd0, inst_valid}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            ifu_req_ready = $urandom_range(0, 1) != 0;
            cycle();
            check("t5_no_req", {63'd0, ifu_req_valid}, 64'd0);
            check("t5_stay_halted", {63'd0, halted}, 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
